branch_predictor: RTL and testbench

Fetch-side branch predictor: bimodal table of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Lookup is combinational on the fetch PC. It produces the taken prediction and target that travel down the pipeline to the execute stage.
- The execute stage returns the resolved outcome (taken, target, mispredict). The predictor consumes it to train its tables and update its performance counters.

---
 rtl/branch_predictor.sv | 107 ++++++++++
 tb/tb_branch_predictor.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter predictor with direct-mapped BTB and perf counters.
// Define BP_TAG_EN to store PC tags and stop aliasing between PCs.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic [XLEN-1:0] pc_F_in,
    output logic            predict_taken_out,
    output logic [XLEN-1:0] predict_target_out,
    input  logic            upd_valid_in,
    input  logic [XLEN-1:0] upd_pc_in,
    input  logic            upd_is_branch_in,
    input  logic            upd_is_jump_in,
    input  logic            upd_taken_in,
    input  logic [XLEN-1:0] upd_target_in,
    input  logic            upd_mispredict_in,
    output logic [31:0]     branch_cnt_out,
    output logic [31:0]     mispredict_cnt_out
);

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [31:0]         branch_cnt_q;
    logic [31:0]         mispredict_cnt_q;

    logic [IDX_BITS-1:0] look_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic                look_hit;
    logic                upd_alloc;
    logic                upd_en;
    logic [1:0]          ctr_next;

    assign look_idx = pc_F_in[IDX_BITS+1:2];
    assign upd_idx  = upd_pc_in[IDX_BITS+1:2];
    assign upd_en   = upd_valid_in & ~stall_in & (upd_is_branch_in | upd_is_jump_in);

`ifdef BP_TAG_EN
    localparam int TAG_W = XLEN - IDX_BITS - 2;

    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [TAG_W-1:0] look_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             unused_bits;

    assign look_tag    = pc_F_in[XLEN-1:IDX_BITS+2];
    assign upd_tag     = upd_pc_in[XLEN-1:IDX_BITS+2];
    assign look_hit    = valid_q[look_idx] & (tag_q[look_idx] == look_tag);
    // A valid entry owned by another PC is replaced as if it were empty
    assign upd_alloc   = ~valid_q[upd_idx] | (tag_q[upd_idx] != upd_tag);
    assign unused_bits = ^{pc_F_in[1:0], upd_pc_in[1:0]};
`else
    logic unused_bits;

    assign look_hit    = valid_q[look_idx];
    assign upd_alloc   = ~valid_q[upd_idx];
    assign unused_bits = ^{pc_F_in[XLEN-1:IDX_BITS+2], pc_F_in[1:0],
                           upd_pc_in[XLEN-1:IDX_BITS+2], upd_pc_in[1:0]};
`endif

    assign predict_taken_out  = look_hit & ctr_q[look_idx][1];
    assign predict_target_out = predict_taken_out ? target_q[look_idx] : '0;
    assign branch_cnt_out     = branch_cnt_q;
    assign mispredict_cnt_out = mispredict_cnt_q;

    always_comb begin
        ctr_next = ctr_q[upd_idx];
        if (upd_is_jump_in) begin
            ctr_next = 2'b11;
        end else if (upd_alloc) begin
            ctr_next = upd_taken_in ? 2'b10 : 2'b01;
        end else if (upd_taken_in) begin
            if (ctr_q[upd_idx] != 2'b11) ctr_next = ctr_q[upd_idx] + 2'd1;
        end else begin
            if (ctr_q[upd_idx] != 2'b00) ctr_next = ctr_q[upd_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= 2'b00;
                target_q[i] <= '0;
`ifdef BP_TAG_EN
                tag_q[i]    <= '0;
`endif
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (upd_en) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (upd_mispredict_in) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= ctr_next;
            if (upd_is_jump_in | upd_taken_in) target_q[upd_idx] <= upd_target_in;
`ifdef BP_TAG_EN
            tag_q[upd_idx] <= upd_tag;
`endif
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run against a behavioural table model.
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IB      = $clog2(ENTRIES);

    logic            clk = 1'b0;
    logic            reset;
    logic            stall_in;
    logic [XLEN-1:0] pc_F_in;
    logic            predict_taken_out;
    logic [XLEN-1:0] predict_target_out;
    logic            upd_valid_in;
    logic [XLEN-1:0] upd_pc_in;
    logic            upd_is_branch_in;
    logic            upd_is_jump_in;
    logic            upd_taken_in;
    logic [XLEN-1:0] upd_target_in;
    logic            upd_mispredict_in;
    logic [31:0]     branch_cnt_out;
    logic [31:0]     mispredict_cnt_out;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_in           (stall_in),
        .pc_F_in            (pc_F_in),
        .predict_taken_out  (predict_taken_out),
        .predict_target_out (predict_target_out),
        .upd_valid_in       (upd_valid_in),
        .upd_pc_in          (upd_pc_in),
        .upd_is_branch_in   (upd_is_branch_in),
        .upd_is_jump_in     (upd_is_jump_in),
        .upd_taken_in       (upd_taken_in),
        .upd_target_in      (upd_target_in),
        .upd_mispredict_in  (upd_mispredict_in),
        .branch_cnt_out     (branch_cnt_out),
        .mispredict_cnt_out (mispredict_cnt_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: one record per table slot, counters as integers
    bit          m_valid [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit owns(input logic [31:0] pc);
`ifdef BP_TAG_EN
        return m_tag[slot(pc)] == (pc >> (IB + 2));
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit mdl_taken(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && owns(pc) && m_ctr[s] >= 2;
    endfunction

    function automatic logic [31:0] mdl_target(input logic [31:0] pc);
        return mdl_taken(pc) ? m_tgt[slot(pc)] : 32'h0;
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_ctr[i] = 0; m_tgt[i] = 0; m_tag[i] = 0;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic void mdl_edge();
        int s;
        if (reset) begin
            mdl_clear();
            return;
        end
        if (!(upd_valid_in && !stall_in && (upd_is_branch_in || upd_is_jump_in)))
            return;
        s = slot(upd_pc_in);
        m_bcnt = m_bcnt + 1;
        if (upd_mispredict_in) m_mcnt = m_mcnt + 1;
        if (upd_is_jump_in) begin
            m_ctr[s] = 3;
            m_tgt[s] = upd_target_in;
        end else begin
            if (!m_valid[s] || !owns(upd_pc_in))
                m_ctr[s] = upd_taken_in ? 2 : 1;
            else if (upd_taken_in)
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
            else
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            if (upd_taken_in) m_tgt[s] = upd_target_in;
        end
        m_valid[s] = 1;
        m_tag[s]   = upd_pc_in >> (IB + 2);
    endfunction

    // Commit the model at the edge, then leave 1 time unit for outputs to settle
    task automatic tick();
        mdl_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall_in = 0; upd_valid_in = 0; upd_pc_in = 0;
        upd_is_branch_in = 0; upd_is_jump_in = 0; upd_taken_in = 0;
        upd_target_in = 0; upd_mispredict_in = 0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input bit br, input bit jmp,
                             input bit tk, input logic [31:0] tgt, input bit mp);
        upd_valid_in = 1; upd_pc_in = pc; upd_is_branch_in = br;
        upd_is_jump_in = jmp; upd_taken_in = tk; upd_target_in = tgt;
        upd_mispredict_in = mp;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pc_F_in = 32'h1000;
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_taken got %0b want 0", predict_taken_out);
        end
        n_checks++;
        if (predict_target_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_target got %h want 0", predict_target_out);
        end
        n_checks++;
        if (branch_cnt_out !== 32'd0 || mispredict_cnt_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnts got %0d/%0d want 0/0",
                     branch_cnt_out, mispredict_cnt_out);
        end
    endtask

    task automatic test_train();
        logic exp_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        pc_F_in = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            if (k < 2) drive_upd(32'h1000, 1, 0, 1, 32'h1040, 0);
            else       drive_upd(32'h1000, 1, 0, 0, 32'h1004, 1);
            tick();
            idle();
            #1;
            n_checks++;
            if (predict_taken_out !== exp_t[k]) begin
                n_fail++;
                $display("FAIL train_taken step %0d got %0b want %0b",
                         k, predict_taken_out, exp_t[k]);
            end
        end
        n_checks++;
        if (predict_target_out !== 32'h0) begin
            n_fail++;
            $display("FAIL train_target_nt got %h want 0", predict_target_out);
        end
        n_checks++;
        if (branch_cnt_out !== 32'd4 || mispredict_cnt_out !== 32'd2) begin
            n_fail++;
            $display("FAIL train_cnts got %0d/%0d want 4/2",
                     branch_cnt_out, mispredict_cnt_out);
        end
        // One taken branch moves weak NT back to weak T
        drive_upd(32'h1000, 1, 0, 1, 32'h1080, 0);
        tick();
        idle();
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b1 || predict_target_out !== 32'h1080) begin
            n_fail++;
            $display("FAIL train_retake got %0b/%h want 1/00001080",
                     predict_taken_out, predict_target_out);
        end
    endtask

    task automatic test_stall_jump();
        do_reset();
        pc_F_in = 32'h2004;
        drive_upd(32'h2004, 0, 1, 1, 32'h3000, 1);
        stall_in = 1;
        tick();
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b0 || branch_cnt_out !== 32'd0 ||
            mispredict_cnt_out !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_drop got %0b cnt %0d/%0d want 0 cnt 0/0",
                     predict_taken_out, branch_cnt_out, mispredict_cnt_out);
        end
        stall_in = 0;
        tick();
        idle();
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b1 || predict_target_out !== 32'h3000) begin
            n_fail++;
            $display("FAIL jump_pred got %0b/%h want 1/00003000",
                     predict_taken_out, predict_target_out);
        end
        n_checks++;
        if (branch_cnt_out !== 32'd1 || mispredict_cnt_out !== 32'd1) begin
            n_fail++;
            $display("FAIL jump_cnts got %0d/%0d want 1/1",
                     branch_cnt_out, mispredict_cnt_out);
        end
        // Jump wins over branch flag; a not-taken branch then only weakens it
        drive_upd(32'h2004, 1, 1, 0, 32'h3100, 0);
        tick();
        drive_upd(32'h2004, 1, 0, 0, 32'h0, 0);
        tick();
        idle();
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b1 || predict_target_out !== 32'h3100) begin
            n_fail++;
            $display("FAIL jump_prio got %0b/%h want 1/00003100",
                     predict_taken_out, predict_target_out);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pc_F_in = 32'h1000;
        drive_upd(32'h1000, 1, 0, 1, 32'h1040, 0);
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b0 || predict_target_out !== 32'h0) begin
            n_fail++;
            $display("FAIL same_cycle_old got %0b/%h want 0/0",
                     predict_taken_out, predict_target_out);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b1 || predict_target_out !== 32'h1040) begin
            n_fail++;
            $display("FAIL same_cycle_new got %0b/%h want 1/00001040",
                     predict_taken_out, predict_target_out);
        end
    endtask

    task automatic test_alias();
        logic            exp_t;
        logic [XLEN-1:0] exp_tg;
`ifdef BP_TAG_EN
        exp_t = 1'b0; exp_tg = 32'h0;
`else
        exp_t = 1'b1; exp_tg = 32'h1040;
`endif
        do_reset();
        drive_upd(32'h1000, 1, 0, 1, 32'h1040, 0);
        tick();
        idle();
        pc_F_in = 32'h1000 + 4 * ENTRIES;
        #1;
        n_checks++;
        if (predict_taken_out !== exp_t || predict_target_out !== exp_tg) begin
            n_fail++;
            $display("FAIL alias got %0b/%h want %0b/%h",
                     predict_taken_out, predict_target_out, exp_t, exp_tg);
        end
    endtask

    task automatic test_reset_dominates();
        do_reset();
        pc_F_in = 32'h1010;
        drive_upd(32'h1010, 1, 0, 1, 32'h2222, 1);
        tick();
        tick();
        reset = 1;
        drive_upd(32'h1010, 0, 1, 1, 32'h4444, 1);
        tick();
        idle();
        #1;
        n_checks++;
        if (predict_taken_out !== 1'b0 || predict_target_out !== 32'h0 ||
            branch_cnt_out !== 32'd0 || mispredict_cnt_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_dom got %0b/%h cnt %0d/%0d want 0/0 cnt 0/0",
                     predict_taken_out, predict_target_out,
                     branch_cnt_out, mispredict_cnt_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            reset             = ($urandom_range(0, 199) == 0);
            stall_in          = ($urandom_range(0, 4) == 0);
            upd_valid_in      = ($urandom_range(0, 4) != 0);
            upd_pc_in         = ($urandom_range(0, 1) << 12) |
                                ($urandom_range(0, ENTRIES - 1) << 2) |
                                $urandom_range(0, 3);
            upd_is_branch_in  = $urandom_range(0, 1);
            upd_is_jump_in    = ($urandom_range(0, 3) == 0);
            upd_taken_in      = $urandom_range(0, 1);
            upd_target_in     = $urandom;
            upd_mispredict_in = $urandom_range(0, 1);
            pc_F_in           = ($urandom_range(0, 1) << 12) |
                                ($urandom_range(0, ENTRIES - 1) << 2) |
                                $urandom_range(0, 3);
            #1;
            n_checks++;
            if (predict_taken_out !== mdl_taken(pc_F_in) ||
                predict_target_out !== mdl_target(pc_F_in)) begin
                n_fail++;
                $display("FAIL rand_pred k=%0d pc=%h got %0b/%h want %0b/%h",
                         k, pc_F_in, predict_taken_out, predict_target_out,
                         mdl_taken(pc_F_in), mdl_target(pc_F_in));
            end
            n_checks++;
            if (branch_cnt_out !== m_bcnt || mispredict_cnt_out !== m_mcnt) begin
                n_fail++;
                $display("FAIL rand_cnts k=%0d got %0d/%0d want %0d/%0d",
                         k, branch_cnt_out, mispredict_cnt_out, m_bcnt, m_mcnt);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        mdl_clear();
        idle();
        pc_F_in = 0;
        test_reset();
        test_train();
        test_stall_jump();
        test_same_cycle();
        test_alias();
        test_reset_dominates();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
